// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte sources,
// with a watchdog that abandons a frame whose tx_done never arrives.
module uart_tx_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned N    = 8,
    parameter int unsigned TMO  = 65536
) (
    input  logic                      i_clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           i_req,
    input  logic [NREQ*N-1:0]         i_data,
    input  logic                      i_tx_ready,
    input  logic                      i_tx_done,
    output logic [N-1:0]              o_data,
    output logic                      o_dv,
    output logic [NREQ-1:0]           o_gnt,
    output logic [$clog2(NREQ)-1:0]   o_owner,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TMO);

    typedef enum logic [1:0] {StIdle, StSend, StWaitDone} state_e;

    state_e        state_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;

    logic [PW-1:0] winner;
    logic [PW-1:0] cand;
    logic          found;
    int unsigned   idx;

    // Scan requesters starting at ptr_q, wrapping modulo NREQ; first set bit wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx  = (32'(ptr_q) + i) % NREQ;
            cand = PW'(idx);
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            o_data  <= '0;
            o_dv    <= 1'b0;
            o_gnt   <= '0;
            o_owner <= '0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A busy transmitter (e.g. still finishing a frame across our reset) blocks grants.
                    if (found && i_tx_ready) begin
                        o_data  <= i_data[32'(winner)*N +: N];
                        o_dv    <= 1'b1;
                        o_gnt   <= NREQ'(1) << winner;
                        o_owner <= winner;
                        ptr_q   <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                        o_busy  <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    o_dv    <= 1'b0;
                    o_gnt   <= '0;
                    cnt_q   <= '0;
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    // Done takes precedence over a simultaneous watchdog expiry.
                    if (i_tx_done) begin
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == CW'(TMO - 1)) begin
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    o_dv    <= 1'b0;
                    o_gnt   <= '0;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a short watchdog (TMO=16).
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned N    = 8;
    localparam int unsigned TMO  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  i_req;
    logic [NREQ*N-1:0] i_data;
    logic             i_tx_ready;
    logic             i_tx_done;
    logic [N-1:0]     o_data;
    logic             o_dv;
    logic [NREQ-1:0]  o_gnt;
    logic [1:0]       o_owner;
    logic             o_busy;
    logic             o_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_byte [4];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ (NREQ),
        .N    (N),
        .TMO  (TMO)
    ) dut (
        .i_clk      (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_tx_ready (i_tx_ready),
        .i_tx_done  (i_tx_done),
        .o_data     (o_data),
        .o_dv       (o_dv),
        .o_gnt      (o_gnt),
        .o_owner    (o_owner),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(o_data), 32'h0);
        check({tag, "_dv"}, 32'(o_dv), 32'h0);
        check({tag, "_gnt"}, 32'(o_gnt), 32'h0);
        check({tag, "_owner"}, 32'(o_owner), 32'h0);
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_err"}, 32'(o_err), 32'h0);
    endtask

    // One full frame: grant, SEND cycle, WAIT_DONE cycle, tx_done pulse.
    task automatic run_frame(input logic [3:0] req, input int w, input string tag);
        i_req = req;
        tick();
        check({tag, "_dv"}, 32'(o_dv), 32'h1);
        check({tag, "_gnt"}, 32'(o_gnt), 32'h1 << w);
        check({tag, "_owner"}, 32'(o_owner), 32'(w));
        check({tag, "_data"}, 32'(o_data), 32'(exp_byte[w]));
        check({tag, "_busy"}, 32'(o_busy), 32'h1);
        tick();
        check({tag, "_dv_off"}, 32'(o_dv), 32'h0);
        check({tag, "_gnt_off"}, 32'(o_gnt), 32'h0);
        check({tag, "_busy_wait"}, 32'(o_busy), 32'h1);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check({tag, "_busy_end"}, 32'(o_busy), 32'h0);
        check({tag, "_err_end"}, 32'(o_err), 32'h0);
    endtask

    initial begin
        exp_byte[0] = 8'h0F;
        exp_byte[1] = 8'h71;
        exp_byte[2] = 8'hA5;
        exp_byte[3] = 8'hD4;
        i_data      = 32'hD4A5_710F;
        rst         = 1'b1;
        i_req       = '0;
        i_tx_ready  = 1'b1;
        i_tx_done   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single request from requester 2.
        run_frame(4'b0100, 2, "single");
        i_req = '0;

        // ptr=3: requester 3 absent, wrap to 0, then 1.
        run_frame(4'b0011, 0, "wrap0");
        run_frame(4'b0011, 1, "wrap1");
        i_req = '0;

        // Reset in WAIT_DONE, then transmitter busy holds off grants; ptr must be back at 0.
        i_req = 4'b0001;
        tick();
        check("rstwait_gnt", 32'(o_gnt), 32'h1);
        i_req = '0;
        tick();
        rst        = 1'b1;
        i_tx_ready = 1'b0;
        tick();
        rst = 1'b0;
        check_all_zero("rst_mid");
        i_req = 4'b0011;
        tick();
        check("notready_dv0", 32'(o_dv), 32'h0);
        tick();
        check("notready_dv1", 32'(o_dv), 32'h0);
        check("notready_busy", 32'(o_busy), 32'h0);
        i_tx_ready = 1'b1;
        tick();
        check("ready_dv", 32'(o_dv), 32'h1);
        check("ready_gnt", 32'(o_gnt), 32'h1);
        check("ready_data", 32'(o_data), 32'(exp_byte[0]));
        i_req = '0;
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("ready_end_busy", 32'(o_busy), 32'h0);

        // tx_done in IDLE is ignored.
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("idle_done_busy", 32'(o_busy), 32'h0);
        check("idle_done_dv", 32'(o_dv), 32'h0);
        check("idle_done_err", 32'(o_err), 32'h0);

        // Round-robin from a fresh pointer with all requesters held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_frame(4'b1111, k % 4, "rr");
        end
        i_req = '0;

        // Watchdog: no tx_done, error after 16 WAIT_DONE cycles.
        i_req = 4'b0100;
        tick();
        check("wd_gnt", 32'(o_gnt), 32'h4);
        i_req = '0;
        tick();
        check("wd_busy", 32'(o_busy), 32'h1);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("wd_err_early", 32'(o_err), 32'h0);
        end
        tick();
        check("wd_err", 32'(o_err), 32'h1);
        check("wd_busy_off", 32'(o_busy), 32'h0);
        tick();
        check("wd_err_pulse", 32'(o_err), 32'h0);
        run_frame(4'b0001, 0, "wd_next");
        i_req = '0;

        // Race: tx_done arrives on the expiry cycle.
        i_req = 4'b0010;
        tick();
        check("race_gnt", 32'(o_gnt), 32'h2);
        i_req = '0;
        tick();
        for (int c = 0; c < 15; c++) begin
            tick();
        end
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("race_err", 32'(o_err), 32'h0);
        check("race_busy", 32'(o_busy), 32'h0);
        tick();
        check("race_err_after", 32'(o_err), 32'h0);
        run_frame(4'b0100, 2, "race_next");
        i_req = '0;

        // tx_done during SEND is ignored; a request dropped while busy is never granted.
        i_req = 4'b1000;
        tick();
        check("senddone_gnt", 32'(o_gnt), 32'h8);
        i_req     = '0;
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("senddone_busy", 32'(o_busy), 32'h1);
        i_req = 4'b0001;
        tick();
        i_req = '0;
        tick();
        check("drop_busy", 32'(o_busy), 32'h1);
        check("drop_dv", 32'(o_dv), 32'h0);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("drop_end_busy", 32'(o_busy), 32'h0);
        tick();
        check("drop_no_dv", 32'(o_dv), 32'h0);
        check("drop_no_gnt", 32'(o_gnt), 32'h0);
        check("data_hold", 32'(o_data), 32'(exp_byte[3]));
        check("owner_hold", 32'(o_owner), 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
